// File: rtl/sprite_anim_seq_pkg.sv
// Shared types and key/direction encodings for the sprite animation sequencer.
// Death-sequence support is selected by the ANIM_DEATH_EN macro in the RTL that imports this.
package sprite_anim_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    DEATH = 3'd4
  } anim_state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_W = 8'h1A;

  localparam logic [1:0] DIR_A = 2'b00;
  localparam logic [1:0] DIR_D = 2'b01;
  localparam logic [1:0] DIR_S = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  function automatic logic key_is_move(input logic [7:0] k);
    return (k == KEY_A) || (k == KEY_D) || (k == KEY_S) || (k == KEY_W);
  endfunction

  function automatic logic [1:0] key_to_dir(input logic [7:0] k);
    logic [1:0] d;
    case (k)
      KEY_D:   d = DIR_D;
      KEY_S:   d = DIR_S;
      KEY_W:   d = DIR_W;
      default: d = DIR_A;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sprite_anim_seq_if.sv
// Control/status bundle between the game logic and the sprite animation sequencer.
// frame_idx width grows to cover the death frames when ANIM_DEATH_EN is defined.
interface sprite_anim_if #(
  parameter int NUM_FRAMES   = 4,
  parameter int DEATH_FRAMES = 8
);
`ifdef ANIM_DEATH_EN
  localparam bit DEATH_EN = 1'b1;
`else
  localparam bit DEATH_EN = 1'b0;
`endif
  localparam int FRAME_W = $clog2(NUM_FRAMES + (DEATH_EN ? DEATH_FRAMES : 0));

  logic               frame_clk;
  logic               playon;
  logic [7:0]         keycode;
  logic               pingpong;
  logic               die;
  logic [FRAME_W-1:0] frame_idx;
  logic [1:0]         move_dir;
  logic               step;
  logic               death_done;

  modport master (
    output frame_clk, playon, keycode, pingpong, die,
    input  frame_idx, move_dir, step, death_done
  );

  modport slave (
    input  frame_clk, playon, keycode, pingpong, die,
    output frame_idx, move_dir, step, death_done
  );
endinterface

// File: rtl/sprite_anim_seq_frame_tick.sv
// Synchronises the vsync-rate frame_clk level, edge-detects it and divides the
// resulting ticks down to a one-Clk animation step pulse.
module frame_tick_gen #(
  parameter int TICKS_PER_STEP = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  input  logic playon,
  output logic step
);
  localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_STEP - 1);

  logic [2:0]       sync_q;
  logic             frame_tick;
  logic [CNT_W-1:0] div_q;

  // sync_q[1] is the synchronised level, sync_q[2] its previous value
  assign frame_tick = sync_q[1] & ~sync_q[2];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      div_q  <= '0;
      step   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      if (!playon) begin
        div_q <= '0;
        step  <= 1'b0;
      end else begin
        step <= frame_tick && (div_q == CNT_LAST);
        if (frame_tick)
          div_q <= (div_q == CNT_LAST) ? '0 : div_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: steps the sprite ROM frame select while a move key is held.
// Define ANIM_DEATH_EN to add the DEATH state and the death_done status.
//
// state | meaning
// IDLE  | game not running, frame 0
// START | start pose, frame 1, waits one step
// RUN   | advancing one frame per step while a move key is held
// HOLD  | no key at last step, frame frozen
// DEATH | playing death frames, then holding the last one
module sprite_anim_seq
  import sprite_anim_pkg::*;
#(
  parameter int NUM_FRAMES     = 4,
  parameter int TICKS_PER_STEP = 8,
  parameter int DEATH_FRAMES   = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  sprite_anim_if.slave  bus
);
`ifdef ANIM_DEATH_EN
  localparam bit DEATH_EN = 1'b1;
`else
  localparam bit DEATH_EN = 1'b0;
`endif
  localparam int FRAME_W = $clog2(NUM_FRAMES + (DEATH_EN ? DEATH_FRAMES : 0));
  localparam logic [FRAME_W-1:0] F_ONE  = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] F_LAST = FRAME_W'(NUM_FRAMES - 1);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_RUN   = RUN;
  localparam logic [2:0] S_HOLD  = HOLD;
  localparam logic [2:0] S_DEATH = DEATH;

  logic [2:0]         state;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-1:0] nxt_frame;
  logic               dir_up;
  logic               nxt_up;
  logic               step;
  logic               key_hit;
  logic               die_go;
  logic               done_q;

  frame_tick_gen #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (bus.frame_clk),
    .playon    (bus.playon),
    .step      (step)
  );

  assign key_hit = key_is_move(bus.keycode);

`ifdef ANIM_DEATH_EN
  localparam logic [FRAME_W-1:0] D_FIRST = FRAME_W'(NUM_FRAMES);
  localparam logic [FRAME_W-1:0] D_LAST  = FRAME_W'(NUM_FRAMES + DEATH_FRAMES - 1);
  assign die_go = bus.die;
`else
  logic unused_die;
  assign unused_die = bus.die;
  assign die_go     = 1'b0;
`endif

  // Loop mode re-arms the up flag so a later switch to ping-pong climbs first
  always_comb begin
    nxt_frame = frame;
    nxt_up    = dir_up;
    if (!bus.pingpong) begin
      nxt_up    = 1'b1;
      nxt_frame = (frame >= F_LAST) ? F_ONE : frame + F_ONE;
    end else if (dir_up) begin
      if (frame >= F_LAST) begin
        nxt_frame = frame - F_ONE;
        nxt_up    = 1'b0;
      end else begin
        nxt_frame = frame + F_ONE;
      end
    end else begin
      if (frame <= F_ONE) begin
        nxt_frame = frame + F_ONE;
        nxt_up    = 1'b1;
      end else begin
        nxt_frame = frame - F_ONE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      frame        <= '0;
      dir_up       <= 1'b1;
      done_q       <= 1'b0;
      bus.move_dir <= DIR_A;
    end else begin
      if (key_hit)
        bus.move_dir <= key_to_dir(bus.keycode);
      if (!bus.playon) begin
        state  <= S_IDLE;
        frame  <= '0;
        dir_up <= 1'b1;
        done_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_START;
            frame  <= F_ONE;
            dir_up <= 1'b1;
          end
          S_START, S_RUN, S_HOLD: begin
`ifdef ANIM_DEATH_EN
            if (die_go) begin
              state <= S_DEATH;
              frame <= D_FIRST;
            end else
`endif
            if (step) begin
              if (state == S_START) begin
                state <= S_RUN;
              end else if (key_hit) begin
                state  <= S_RUN;
                frame  <= nxt_frame;
                dir_up <= nxt_up;
              end else begin
                state <= S_HOLD;
              end
            end
          end
`ifdef ANIM_DEATH_EN
          S_DEATH: begin
            if (step && !done_q) begin
              frame <= frame + F_ONE;
              if (frame == D_LAST - F_ONE)
                done_q <= 1'b1;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.frame_idx  = frame;
  assign bus.step       = step;
  assign bus.death_done = done_q;
endmodule

// File: tb/tb_sprite_anim_seq.sv
// Bench for sprite_anim_seq: table of per-step vectors checked through a scoreboard,
// plus hand-written reset, playon-drop and death/die sequences.
module tb_sprite_anim_seq;
  import sprite_anim_pkg::*;

  localparam int TPS = 8;
  localparam int NF  = 4;
  localparam int DF  = 8;
`ifdef ANIM_DEATH_EN
  localparam bit DEATH_EN = 1'b1;
`else
  localparam bit DEATH_EN = 1'b0;
`endif
  localparam int FW = $clog2(NF + (DEATH_EN ? DF : 0));

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  sprite_anim_if u_if ();

  sprite_anim_seq dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (u_if.slave)
  );

  typedef struct {
    logic [FW-1:0] frame;
    logic [1:0]    dir;
  } exp_t;

  typedef struct {
    bit            restart;
    bit            pp;
    logic [7:0]    key;
    logic [FW-1:0] frame;
    logic [1:0]    dir;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   step_seen = 1'b0;

  // Frame update lands one Clk after the step pulse
  always @(negedge Clk) begin
    if (step_seen) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_step frame=%0d dir=%0d (no expectation queued)",
                 u_if.frame_idx, u_if.move_dir);
      end else begin
        e = sb.pop_front();
        if (u_if.frame_idx !== e.frame || u_if.move_dir !== e.dir) begin
          n_bad++;
          $display("FAIL step_out frame=%0d dir=%0d expected frame=%0d dir=%0d",
                   u_if.frame_idx, u_if.move_dir, e.frame, e.dir);
        end
      end
    end
    step_seen = (u_if.step === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      u_if.frame_clk = 1'b1;
      tick(4);
      u_if.frame_clk = 1'b0;
      tick(4);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL step_timeout pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_step(input int fr, input int dr);
    sb.push_back('{frame: FW'(fr), dir: 2'(dr)});
    pulses(TPS);
    drain();
  endtask

  task automatic restart();
    u_if.playon = 1'b0;
    tick(2);
    check("idle_frame", u_if.frame_idx, 0);
    u_if.playon = 1'b1;
    tick(1);
    check("start_frame", u_if.frame_idx, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // restart, pingpong, key, expected frame, expected move_dir
    vt.push_back('{1, 0, KEY_D, 1, DIR_D});
    vt.push_back('{0, 0, KEY_D, 2, DIR_D});
    vt.push_back('{0, 0, KEY_D, 3, DIR_D});
    vt.push_back('{0, 0, KEY_D, 1, DIR_D});
    vt.push_back('{0, 0, KEY_D, 2, DIR_D});
    vt.push_back('{1, 1, KEY_W, 1, DIR_W});
    vt.push_back('{0, 1, KEY_W, 2, DIR_W});
    vt.push_back('{0, 1, KEY_W, 3, DIR_W});
    vt.push_back('{0, 1, KEY_W, 2, DIR_W});
    vt.push_back('{0, 1, KEY_W, 1, DIR_W});
    vt.push_back('{0, 1, KEY_W, 2, DIR_W});
    vt.push_back('{1, 0, KEY_D, 1, DIR_D});
    vt.push_back('{0, 0, KEY_D, 2, DIR_D});
    vt.push_back('{0, 0, 8'h00, 2, DIR_D});
    vt.push_back('{0, 0, 8'h00, 2, DIR_D});
    vt.push_back('{0, 0, 8'h00, 2, DIR_D});
    vt.push_back('{0, 0, KEY_A, 3, DIR_A});
    vt.push_back('{0, 0, KEY_A, 1, DIR_A});
    vt.push_back('{0, 1, KEY_A, 2, DIR_A});
    vt.push_back('{0, 1, KEY_A, 3, DIR_A});
    vt.push_back('{0, 1, KEY_A, 2, DIR_A});
    vt.push_back('{0, 0, KEY_A, 3, DIR_A});
    vt.push_back('{0, 0, KEY_A, 1, DIR_A});
    vt.push_back('{0, 0, 8'h05, 1, DIR_A});
    vt.push_back('{0, 0, KEY_S, 2, DIR_S});

    u_if.frame_clk = 1'b0;
    u_if.playon    = 1'b0;
    u_if.keycode   = 8'h00;
    u_if.pingpong  = 1'b0;
    u_if.die       = 1'b0;
    tick(3);
    check("rst_frame", u_if.frame_idx, 0);
    check("rst_dir", u_if.move_dir, 0);
    check("rst_step", u_if.step, 0);
    check("rst_done", u_if.death_done, 0);
    Reset_n = 1'b1;
    tick(2);

    foreach (vt[i]) begin
      u_if.pingpong = vt[i].pp;
      u_if.keycode  = vt[i].key;
      if (vt[i].restart) restart();
      do_step(vt[i].frame, vt[i].dir);
    end

    // playon drop between steps, then the divider must restart from zero
    u_if.pingpong = 1'b0;
    u_if.keycode  = KEY_D;
    restart();
    do_step(1, DIR_D);
    do_step(2, DIR_D);
    pulses(3);
    u_if.playon = 1'b0;
    tick(1);
    check("drop_frame", u_if.frame_idx, 0);
    u_if.playon = 1'b1;
    tick(1);
    check("reenable_frame", u_if.frame_idx, 1);
    sb.push_back('{frame: FW'(1), dir: DIR_D});
    pulses(TPS - 1);
    check("div_restart_pending", sb.size(), 1);
    pulses(1);
    drain();
    do_step(2, DIR_D);

    // asynchronous reset mid-RUN at frame 2
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_frame", u_if.frame_idx, 0);
    check("async_rst_dir", u_if.move_dir, 0);
    check("async_rst_step", u_if.step, 0);
    #3;
    Reset_n = 1'b1;
    u_if.keycode = 8'h00;
    tick(2);
    check("post_rst_start", u_if.frame_idx, 1);
    check("post_rst_dir", u_if.move_dir, 0);

`ifdef ANIM_DEATH_EN
    u_if.keycode = KEY_D;
    restart();
    do_step(1, DIR_D);
    do_step(2, DIR_D);
    u_if.die = 1'b1;
    tick(1);
    u_if.die = 1'b0;
    check("death_entry_frame", u_if.frame_idx, NF);
    check("death_entry_done", u_if.death_done, 0);
    for (int f = NF + 1; f < NF + DF; f++) begin
      u_if.keycode = (f % 2 == 0) ? 8'h00 : KEY_D;
      do_step(f, DIR_D);
    end
    check("death_done_set", u_if.death_done, 1);
    do_step(NF + DF - 1, DIR_D);
    check("death_hold_done", u_if.death_done, 1);
    u_if.playon = 1'b0;
    tick(1);
    check("death_exit_frame", u_if.frame_idx, 0);
    check("death_exit_done", u_if.death_done, 0);
`else
    u_if.keycode = KEY_D;
    restart();
    do_step(1, DIR_D);
    do_step(2, DIR_D);
    u_if.die = 1'b1;
    tick(2);
    u_if.die = 1'b0;
    check("die_ignored_frame", u_if.frame_idx, 2);
    check("die_ignored_done", u_if.death_done, 0);
    do_step(3, DIR_D);
`endif

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
